// File: rtl/enigma_tx_formatter.sv
// Output stage between the Enigma cipher and the UART transmitter: buffers cipher
// bytes and emits letters in groups of GROUP_LEN with spaces and CR LF line breaks.
module enigma_tx_formatter #(
  parameter int DEPTH           = 16,
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 5
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Data_DV,
  input  logic [7:0]               i_Data,
  input  logic                     i_Flush,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Empty,
  output logic                     o_Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(GROUP_LEN + 1);
  localparam int GW = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SEP_SP = 3'd3;
  localparam logic [2:0] S_SEP_CR = 3'd4;
  localparam logic [2:0] S_SEP_LF = 3'd5;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    state_q, state_d;
  logic [LW-1:0] letter_cnt_q, letter_cnt_d;
  logic [GW-1:0] group_cnt_q, group_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          wait_lf_q, wait_lf_d;
  logic          pop_pend_q, pop_pend_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;

  logic       empty_s, full_s, push_s, pop_s, head_letter_s, flush_clr_s;
  logic [7:0] head_s;

  assign empty_s       = (count_q == '0);
  assign full_s        = (count_q == (AW+1)'(DEPTH));
  assign head_s        = mem[rd_ptr_q];
  assign head_letter_s = (head_s >= 8'h41) && (head_s <= 8'h5A);
  // The head is retired one cycle after it is issued, while the FSM sits in WAIT.
  assign pop_s         = pop_pend_q;
  assign push_s        = i_Data_DV && (!full_s || pop_s);

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (i_Data_DV && full_s && !pop_s) ovf_d = 1'b1;
    else                               ovf_d = ovf_q;
  end

  // Formatter FSM: chooses the next byte and maintains the group/line counters.
  always_comb begin
    state_d      = state_q;
    letter_cnt_d = letter_cnt_q;
    group_cnt_d  = group_cnt_q;
    wait_lf_d    = wait_lf_q;
    pop_pend_d   = 1'b0;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    flush_clr_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Tx_Active) begin
          state_d = S_IDLE;
        end else if (!empty_s && head_letter_s && (letter_cnt_q == LW'(GROUP_LEN))) begin
          if (group_cnt_q == GW'(GROUPS_PER_LINE - 1)) state_d = S_SEP_CR;
          else                                         state_d = S_SEP_SP;
        end else if (!empty_s) begin
          tx_dv_d    = 1'b1;
          tx_byte_d  = head_s;
          pop_pend_d = 1'b1;
          wait_lf_d  = 1'b0;
          state_d    = S_WAIT;
          if (head_letter_s) letter_cnt_d = letter_cnt_q + LW'(1);
          else               letter_cnt_d = letter_cnt_q;
        end else if (flush_pend_q) begin
          flush_clr_s = 1'b1;
          if ((letter_cnt_q != '0) || (group_cnt_q != '0)) state_d = S_SEP_CR;
          else                                             state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEP_SP: begin
        tx_dv_d      = 1'b1;
        tx_byte_d    = 8'h20;
        letter_cnt_d = '0;
        group_cnt_d  = group_cnt_q + GW'(1);
        wait_lf_d    = 1'b0;
        state_d      = S_WAIT;
      end
      S_SEP_CR: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = 8'h0D;
        wait_lf_d = 1'b1;
        state_d   = S_WAIT;
      end
      S_SEP_LF: begin
        tx_dv_d      = 1'b1;
        tx_byte_d    = 8'h0A;
        letter_cnt_d = '0;
        group_cnt_d  = '0;
        wait_lf_d    = 1'b0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) state_d = wait_lf_q ? S_SEP_LF : S_IDLE;
        else           state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    // A new flush request wins over clearing an older one.
    if (i_Flush)          flush_pend_d = 1'b1;
    else if (flush_clr_s) flush_pend_d = 1'b0;
    else                  flush_pend_d = flush_pend_q;
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_Clk) begin
    if (push_s) mem[wr_ptr_q] <= i_Data;
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      state_q      <= S_IDLE;
      letter_cnt_q <= '0;
      group_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      wait_lf_q    <= 1'b0;
      pop_pend_q   <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      letter_cnt_q <= letter_cnt_d;
      group_cnt_q  <= group_cnt_d;
      flush_pend_q <= flush_pend_d;
      wait_lf_q    <= wait_lf_d;
      pop_pend_q   <= pop_pend_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
    end
  end

  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Count    = count_q;
  assign o_Empty    = empty_s;
  assign o_Overflow = ovf_q;

endmodule
